// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared pipelined ALU: grants one requester per cycle and
// routes each result back to its owner through a latency-matched tag pipe.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 64,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned IdW    = $clog2(NUM_REQ),
    localparam int unsigned InfW   = $clog2(LATENCY + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_opcode,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic [3:0]           alu_opcode,
    output logic [W-1:0]         alu_in1,
    output logic [W-1:0]         alu_in2,
    output logic [4:0]           alu_shift,
    input  logic [W-1:0]         alu_result,
    input  logic                 alu_carry,
    output logic                 resp_valid,
    output logic [IdW-1:0]       resp_id,
    output logic [W-1:0]         resp_result,
    output logic                 resp_carry,
    output logic                 resp_err,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic [InfW-1:0]      inflight
);

    localparam int unsigned Last = LATENCY - 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [InfW-1:0] inflight_q, inflight_d;

    logic            tag_vld_q [LATENCY];
    logic [IdW-1:0]  tag_id_q  [LATENCY];
    logic [3:0]      tag_op_q  [LATENCY];

    logic [IdW-1:0]  cand [NUM_REQ];
    logic            grant_en;
    logic            grant_vld;
    logic [IdW-1:0]  grant_id;
    logic            xfer;

    // Search order starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand[k] = IdW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!grant_vld && req_valid[cand[k]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[k];
            end
        end
    end

    assign xfer = grant_en && grant_vld;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Idle issue slot presents an illegal opcode so the ALU produces 0 and holds carry.
    always_comb begin
        alu_opcode = 4'hF;
        alu_in1    = '0;
        alu_in2    = '0;
        if (xfer) begin
            alu_opcode = req_opcode[grant_id*4 +: 4];
            alu_in1    = req_a[grant_id*W +: W];
            alu_in2    = req_b[grant_id*W +: W];
        end
    end

    assign alu_shift = '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (int'(grant_id) == int'(NUM_REQ) - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id + 1'b1;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, resp_valid})
            2'b10:   inflight_d = inflight_q + InfW'(1);
            2'b01:   inflight_d = inflight_q - InfW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
                tag_op_q[i]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= xfer;
            tag_id_q[0]  <= grant_id;
            tag_op_q[0]  <= alu_opcode;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
                tag_op_q[i]  <= tag_op_q[i-1];
            end
        end
    end

    // Final tag stage lines up with the ALU result register.
    always_comb begin
        resp_valid  = tag_vld_q[Last];
        resp_id     = resp_valid ? tag_id_q[Last] : '0;
        resp_result = resp_valid ? alu_result : '0;
        resp_carry  = resp_valid && (tag_op_q[Last][3:1] == 3'd0) && alu_carry;
        resp_err    = resp_valid && (tag_op_q[Last] > 4'd3);
    end

    assign inflight = inflight_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (drain_req) state_d = StDrain;
            end
            StDrain: begin
                if (!drain_req) begin
                    state_d = StRun;
                end else if (inflight_d == '0) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!drain_req) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        grant_en   = rst_n && (state_q == StRun) && !drain_req;
        drain_done = (state_q == StHalt);
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a two-stage ALU stub, a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_rr_scheduler;

    localparam int N = 4;
    localparam int L = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [4*N-1:0]  req_opcode;
    logic [64*N-1:0] req_a;
    logic [64*N-1:0] req_b;
    logic [3:0]    alu_opcode;
    logic [63:0]   alu_in1;
    logic [63:0]   alu_in2;
    logic [4:0]    alu_shift;
    logic [63:0]   alu_result = '0;
    logic          alu_carry = 1'b0;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [63:0]   resp_result;
    logic          resp_carry;
    logic          resp_err;
    logic          drain_req;
    logic          drain_done;
    logic [2:0]    inflight;

    int n_vec = 0;
    int n_err = 0;

    alu_rr_scheduler #(.NUM_REQ(N), .W(64), .LATENCY(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_opcode  (alu_opcode),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_shift   (alu_shift),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_err    (resp_err),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .inflight    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {carry, result}; carry meaningful only for ADD/SUB
    function automatic logic [64:0] alu_f(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {a < b, a - b};
            4'd2:    return {1'b0, a * b};
            4'd3:    return {1'b0, ~(a & b)};
            default: return 65'd0;
        endcase
    endfunction

    // ALU stub: input register then result register; MUL/NAND force carry high to expose masking.
    logic [3:0]  s_op = 4'hF;
    logic [63:0] s_a  = '0;
    logic [63:0] s_b  = '0;
    always @(posedge clk) begin
        logic [64:0] r;
        r = alu_f(s_op, s_a, s_b);
        alu_result <= r[63:0];
        if (s_op <= 4'd3) alu_carry <= (s_op < 4'd2) ? r[64] : 1'b1;
        s_op <= alu_opcode;
        s_a  <= alu_in1;
        s_b  <= alu_in2;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        int          id;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    int          cyc  = 0;
    int          rr   = 0;
    int          mode = 0;  // 0 run, 1 drain, 2 halt
    bit          init = 0;
    int          g;
    bit          rv;
    logic [3:0]  x_op;
    logic [63:0] x_a, x_b;
    logic [64:0] x_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            init = 1;
            rr   = 0;
            mode = 0;
            q.delete();
        end else if (init) begin
            g = -1;
            if (mode == 0 && !drain_req) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
                end
            end
            chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                x_op = req_opcode[4*g +: 4];
                x_a  = req_a[64*g +: 64];
                x_b  = req_b[64*g +: 64];
            end else begin
                x_op = 4'hF;
                x_a  = '0;
                x_b  = '0;
            end
            chk("alu_opcode", alu_opcode, x_op);
            chk("alu_in1", alu_in1, x_a);
            chk("alu_in2", alu_in2, x_b);
            chk("alu_shift", alu_shift, 0);
            chk("inflight", inflight, q.size());
            chk("drain_done", drain_done, mode == 2);
            rv = (q.size() != 0) && (q[0].due == cyc);
            chk("resp_valid", resp_valid, rv);
            if (rv) begin
                e = q.pop_front();
                x_r = alu_f(e.op, e.a, e.b);
                chk("resp_id", resp_id, e.id);
                chk("resp_result", resp_result, x_r[63:0]);
                chk("resp_carry", resp_carry, (e.op < 4'd2) ? x_r[64] : 1'b0);
                chk("resp_err", resp_err, e.op > 4'd3);
            end
            if (g >= 0) begin
                q.push_back('{due: cyc + L, id: g, op: x_op, a: x_a, b: x_b});
                rr = (g + 1) % N;
            end
            case (mode)
                0: if (drain_req) mode = 1;
                1: if (!drain_req) mode = 0; else if (q.size() == 0) mode = 2;
                default: if (!drain_req) mode = 0;
            endcase
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req_valid = '0;
        drain_req = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b);
        req_opcode[4*i +: 4] = op;
        req_a[64*i +: 64]    = a;
        req_b[64*i +: 64]    = b;
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        rst_n = 1'b0;
        req_valid = '0;
        req_opcode = '0;
        req_a = '0;
        req_b = '0;
        drain_req = 1'b0;

        // Reset state
        step();
        @(negedge clk);
        chk("rst_inflight", inflight, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_opcode", alu_opcode, 4'hF);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_resp_result", resp_result, 0);
        step();
        rst_n = 1'b1;

        // Single ADD with carry out
        req_valid = 4'b0001;
        set_req(0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_early", resp_valid, 0);
        @(negedge clk);
        chk("t1_valid", resp_valid, 1);
        chk("t1_id", resp_id, 0);
        chk("t1_result", resp_result, 0);
        chk("t1_carry", resp_carry, 1);

        // Fairness
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) set_req(i, 4'd3, {$urandom, $urandom}, {$urandom, $urandom});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_grant", req_ready, 4'b0001 << (k % 4));
            if (k >= 2) begin
                chk("t2_resp_valid", resp_valid, 1);
                chk("t2_resp_id", resp_id, (k - 2) % 4);
            end
            step();
        end
        req_valid = '0;

        // Carry masking: SUB then MUL back to back
        req_valid = 4'b0001;
        set_req(0, 4'd1, 64'd3, 64'd5);
        @(negedge clk);
        chk("t3_ready0", req_ready, 4'b0001);
        step();
        set_req(0, 4'd2, 64'd2, 64'd3);
        @(negedge clk);
        chk("t3_ready1", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t3_sub_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3_sub_carry", resp_carry, 1);
        @(negedge clk);
        chk("t3_mul_valid", resp_valid, 1);
        chk("t3_mul_result", resp_result, 64'd6);
        chk("t3_mul_carry", resp_carry, 0);

        // Illegal opcode
        step();
        req_valid = 4'b0100;
        set_req(2, 4'h9, 64'd7, 64'd8);
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid", resp_valid, 1);
        chk("t4_id", resp_id, 2);
        chk("t4_result", resp_result, 0);
        chk("t4_err", resp_err, 1);
        chk("t4_carry", resp_carry, 0);

        // Drain
        step();
        req_valid = 4'b0001;
        set_req(0, 4'd0, 64'd10, 64'd20);
        @(negedge clk);
        chk("t5_ready0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0010;
        set_req(1, 4'd1, 64'd5, 64'd1);
        @(negedge clk);
        chk("t5_ready1", req_ready, 4'b0010);
        step();
        req_valid = 4'hF;
        drain_req = 1'b1;
        @(negedge clk);
        chk("t5_ready_c2", req_ready, 0);
        chk("t5_resp0_id", resp_valid ? resp_id : 2'd3, 0);
        step();
        @(negedge clk);
        chk("t5_ready_c3", req_ready, 0);
        chk("t5_resp1_id", resp_valid ? resp_id : 2'd3, 1);
        chk("t5_done_c3", drain_done, 0);
        step();
        @(negedge clk);
        chk("t5_done_c4", drain_done, 1);
        chk("t5_inflight_c4", inflight, 0);
        chk("t5_resp_c4", resp_valid, 0);
        step();
        drain_req = 1'b0;
        @(negedge clk);
        chk("t5_ready_c5", req_ready, 0);
        chk("t5_done_c5", drain_done, 1);
        step();
        @(negedge clk);
        chk("t5_ready_c6", req_ready, 4'b0100);
        chk("t5_done_c6", drain_done, 0);
        step();
        req_valid = '0;

        // Reset mid-flight
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 4'd2, 64'd6, 64'd7);
        @(negedge clk);
        chk("t6_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_resp", resp_valid, 0);
            chk("t6_inflight", inflight, 0);
            step();
        end
        req_valid = 4'hF;
        @(negedge clk);
        chk("t6_rr_ptr", req_ready, 4'b0001);
        step();
        req_valid = '0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (drain_req) begin
                if ($urandom_range(0, 5) == 0) drain_req = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                drain_req = 1'b1;
            end
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3))
                                                : 4'($urandom_range(0, 15));
                a  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                 : 64'($urandom_range(0, 15));
                b  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                 : 64'($urandom_range(0, 15));
                set_req(i, op, a, b);
            end
            step();
        end
        rst_n = 1'b1;
        req_valid = '0;
        drain_req = 1'b0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
